stage_sink: RTL and testbench
=============================

Name: stage_sink

Overview:
- Terminal consumer for the stage handshake (DIR / data / ack). Sits at the output end of a stage chain and takes DOR and data_out from the last stage.
- Accepts words with a four-phase handshake and buffers them in a small first-word-fall-through FIFO.
- Exposes a simple read port to local logic, plus a running checksum and an accepted-word counter for monitoring.

Parameters:
- WIDTH, 8, data word width.
- DEPTH_LOG2, 2, log2 of FIFO depth (default depth 4).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- DIR  input  1  data-in-ready from the upstream stage (its DOR).
- data_in  input  WIDTH  upstream data; stable while DIR=1.
- ack_out  output  1  acknowledge to upstream (upstream's ack_to input).
- rd_en  input  1  pop the head word.
- rd_data  output  WIDTH  head word (FWFT); don't-care when empty.
- empty  output  1  FIFO holds no words.
- full  output  1  FIFO holds 2^DEPTH_LOG2 words.
- count  output  DEPTH_LOG2+1  words currently held.
- checksum  output  WIDTH  sum of all accepted words, mod 2^WIDTH.
- word_cnt  output  16  number of accepted words, wraps 0xFFFF->0.

Behaviour:
- Reset (async, immediate): ack_out=0, state=IDLE, rd_ptr=wr_ptr=0, count=0, empty=1, full=0, checksum=0, word_cnt=0. FIFO contents are not cleared.
- Handshake, four-phase:
  - Upstream raises DIR with data_in stable.
  - Sink captures the word and raises ack_out.
  - Upstream drops DIR.
  - Sink drops ack_out.
- State IDLE (ack_out=0):
  - On an edge with DIR=1 and full=0: write data_in at wr_ptr, wr_ptr++, checksum+=data_in, word_cnt++, ack_out<=1, go to ACK.
  - On an edge with DIR=1 and full=1: no capture; ack_out stays 0 (backpressure). Capture occurs on the first edge after full falls.
  - DIR=0: stay in IDLE.
- State ACK (ack_out=1):
  - DIR=1: hold; no further capture.
  - On an edge with DIR=0: ack_out<=0, go to IDLE.
- Latency and throughput:
  - DIR sampled high at edge n gives ack_out=1, empty=0 and count incremented, all visible after edge n.
  - DIR sampled low at edge m gives ack_out=0 after edge m.
  - Peak rate is one word per 2 cycles.
- Read side:
  - rd_data = mem[rd_ptr], combinational.
  - On an edge with rd_en=1 and empty=0: rd_ptr++, count--.
  - rd_en while empty: ignored; no pointer or count change.
- Simultaneous capture and pop on the same edge (not full, not empty): both take effect; count is unchanged.
- full/empty are derived from the registered count, as evaluated before the edge. A pop while full does not allow a capture on that same edge.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. count saturates by construction: no overflow or underflow is possible.
- checksum: WIDTH-bit add, carry discarded.
- Reset during ACK: ack_out drops immediately and the FSM returns to IDLE. Upstream is required to tolerate the lost ack. A word already captured is discarded together with the FIFO.

Test Plan:
- Reset then idle -> ack_out=0, empty=1, full=0, count=0, checksum=0x00, word_cnt=0.
- Single handshake with data_in=0xA5 -> ack_out high one edge after DIR high; rd_data=0xA5, count=1; ack_out low one edge after DIR low; rd_en pulse -> empty=1.
- Push 0x01,0x02,0x03,0x04 with no reads, then present 0x05 -> full=1, ack_out held 0. One rd_en pops 0x01; the next edge captures 0x05. Subsequent reads return 0x02,0x03,0x04,0x05.
- Interleave continuous pushes and pops for 10 words (with count=1 at the start of the run) -> count constant on simultaneous edges; output order matches input; rd_en when empty is ignored.
- Accept 0xFF,0x02 -> checksum=0x01. Preload word_cnt at 0xFFFF via 65535 words, then accept one more -> word_cnt wraps to 0.
- Assert reset while ack_out=1 and count=2 -> ack_out, count and checksum all 0 immediately (asynchronous), empty=1. After release, a new handshake with data_in=0x3C completes normally.

Source files
------------

// File: rtl/stage_sink.sv
// Terminal sink for the DIR/ack four-phase stage handshake: captures words into a
// first-word-fall-through FIFO and keeps a running checksum and accepted-word count.
module stage_sink #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  DIR,
    input  logic [WIDTH-1:0]      data_in,
    output logic                  ack_out,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic [WIDTH-1:0]      checksum,
    output logic [15:0]           word_cnt
);

    localparam int                  DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  ack_q, ack_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic [WIDTH-1:0]      checksum_q, checksum_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic                  capture_s;
    logic                  pop_s;
    logic [WIDTH-1:0]      mem_r [DEPTH];

    // Next-state logic: handshake FSM, FIFO bookkeeping and monitoring counters.
    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        checksum_d = checksum_q;
        word_cnt_d = word_cnt_q;
        capture_s  = 1'b0;
        pop_s      = rd_en & ~empty_q;

        // full_q is the pre-edge view, so a pop while full cannot free room for this edge's capture
        case (state_q)
            IDLE: begin
                if (DIR && !full_q) begin
                    capture_s = 1'b1;
                    state_d   = ACK;
                    ack_d     = 1'b1;
                end else begin
                    state_d   = IDLE;
                    ack_d     = 1'b0;
                end
            end
            ACK: begin
                if (!DIR) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end else begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
            end
        endcase

        if (capture_s) begin
            wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(1);
            checksum_d = checksum_q + data_in;
            word_cnt_d = word_cnt_q + 16'd1;
        end else begin
            wr_ptr_d   = wr_ptr_q;
            checksum_d = checksum_q;
            word_cnt_d = word_cnt_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({capture_s, pop_s})
            2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase

        empty_d = (count_d == (DEPTH_LOG2 + 1)'(0));
        full_d  = (count_d == DEPTH_C);
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            checksum_q <= '0;
            word_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            checksum_q <= checksum_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // FIFO storage; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (capture_s) begin
            mem_r[wr_ptr_q] <= data_in;
        end
    end

    assign rd_data  = mem_r[rd_ptr_q];
    assign ack_out  = ack_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;
    assign checksum = checksum_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_stage_sink.sv
// Bench for stage_sink: constant vector table, directed corner sequences and a
// randomized run, all checked against a queue-based model of the sink.
module tb_stage_sink;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dir = 1'b0;
    logic [7:0] din = 8'h00;
    logic       rd  = 1'b0;
    logic       ack_out;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic [7:0] checksum;
    logic [15:0] word_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  q_m [$];
    logic [7:0]  cks_m;
    logic [15:0] wcnt_m;
    logic        ack_m;

    typedef struct {
        logic       dir;
        logic [7:0] din;
        logic       rd;
        logic       ack;
        logic [2:0] cnt;
        logic       chk_rd;
        logic [7:0] rdd;
        logic       emp;
        logic       ful;
    } vec_t;

    vec_t vecs [18];

    stage_sink #(.WIDTH(8), .DEPTH_LOG2(2)) dut (
        .clk      (clk),
        .reset    (rst),
        .DIR      (dir),
        .data_in  (din),
        .ack_out  (ack_out),
        .rd_en    (rd),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .checksum (checksum),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        cks_m  = 8'h00;
        wcnt_m = 16'h0000;
        ack_m  = 1'b0;
    endtask

    // One clock edge of the sink described by its rules, not its implementation.
    task automatic model_edge(input logic d, input logic [7:0] di, input logic r);
        bit do_pop;
        bit do_cap;
        do_pop = r && (q_m.size() > 0);
        do_cap = !ack_m && d && (q_m.size() < 4);
        if (do_pop) void'(q_m.pop_front());
        if (do_cap) begin
            q_m.push_back(di);
            cks_m  = cks_m + di;
            wcnt_m = wcnt_m + 16'd1;
        end
        ack_m = ack_m ? d : do_cap;
    endtask

    task automatic check_model();
        chk("m_ack",   32'(ack_out),  32'(ack_m));
        chk("m_count", 32'(count),    32'(q_m.size()));
        chk("m_empty", 32'(empty),    32'(q_m.size() == 0));
        chk("m_full",  32'(full),     32'(q_m.size() == 4));
        if (q_m.size() > 0) chk("m_rd_data", 32'(rd_data), 32'(q_m[0]));
        chk("m_checksum", 32'(checksum), 32'(cks_m));
        chk("m_word_cnt", 32'(word_cnt), 32'(wcnt_m));
    endtask

    task automatic step(input logic d, input logic [7:0] di, input logic r);
        dir = d;
        din = di;
        rd  = r;
        @(posedge clk);
        model_edge(d, di, r);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dir = 1'b0;
        rd  = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] di);
        step(1'b1, di, 1'b0);
        step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic       udir;
        logic [7:0] udata;

        // dir din rd | ack cnt chk_rd rdd empty full
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 3'd1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 8'h01, 1'b0, 1'b1, 3'd1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h02, 1'b0, 1'b1, 3'd2, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h03, 1'b0, 1'b1, 3'd3, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h04, 1'b0, 1'b1, 3'd4, 1'b1, 8'h01, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 1'b1, 8'h01, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 8'h05, 1'b0, 1'b0, 3'd4, 1'b1, 8'h01, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 8'h05, 1'b1, 1'b0, 3'd3, 1'b1, 8'h02, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 8'h05, 1'b0, 1'b1, 3'd4, 1'b1, 8'h02, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b1, 8'h04, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 8'h05, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0};

        model_reset();
        do_reset();
        chk("rst_ack",      32'(ack_out),  32'h0);
        chk("rst_empty",    32'(empty),    32'h1);
        chk("rst_full",     32'(full),     32'h0);
        chk("rst_count",    32'(count),    32'h0);
        chk("rst_checksum", 32'(checksum), 32'h00);
        chk("rst_word_cnt", 32'(word_cnt), 32'h0);

        // Single handshake, fill to full, backpressure and release, drain
        for (int i = 0; i < 18; i++) begin
            step(vecs[i].dir, vecs[i].din, vecs[i].rd);
            chk($sformatf("vec%0d_ack", i),   32'(ack_out), 32'(vecs[i].ack));
            chk($sformatf("vec%0d_count", i), 32'(count),   32'(vecs[i].cnt));
            chk($sformatf("vec%0d_empty", i), 32'(empty),   32'(vecs[i].emp));
            chk($sformatf("vec%0d_full", i),  32'(full),    32'(vecs[i].ful));
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].rdd));
        end
        chk("vec_checksum", 32'(checksum), 32'hB4);

        // Interleaved push/pop starting from one held word
        push(8'h10);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 8'h20 + 8'(k), 1'b1);
            chk("inter_count_const", 32'(count), 32'd1);
            step(1'b0, 8'h00, 1'b0);
        end
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("inter_rd_when_empty", 32'(count), 32'd0);

        // Checksum wrap
        do_reset();
        push(8'hFF);
        push(8'h02);
        chk("checksum_wrap", 32'(checksum), 32'h01);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // word_cnt wrap: start the counter at 0xFFFF instead of pushing 65535 words
        force dut.word_cnt_q = 16'hFFFF;
        #1;
        release dut.word_cnt_q;
        wcnt_m = 16'hFFFF;
        #1;
        push(8'h11);
        chk("word_cnt_wrap", 32'(word_cnt), 32'h0);
        step(1'b0, 8'h00, 1'b1);

        // Reset asserted mid-cycle while ack_out=1 and count=2
        do_reset();
        push(8'h41);
        step(1'b1, 8'h42, 1'b0);
        chk("pre_rst_count", 32'(count),   32'd2);
        chk("pre_rst_ack",   32'(ack_out), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ack",      32'(ack_out),  32'h0);
        chk("async_rst_count",    32'(count),    32'h0);
        chk("async_rst_checksum", 32'(checksum), 32'h0);
        chk("async_rst_empty",    32'(empty),    32'h1);
        model_reset();
        dir = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        push(8'h3C);
        chk("post_rst_rd_data", 32'(rd_data), 32'h3C);
        chk("post_rst_count",   32'(count),   32'd1);

        // Randomized protocol-compliant upstream and random reader
        udir  = 1'b0;
        udata = 8'h00;
        for (int n = 0; n < 600; n++) begin
            if (!udir) begin
                if ($urandom_range(0, 2) != 0) begin
                    udir  = 1'b1;
                    udata = 8'($urandom);
                end
            end else if (ack_m && $urandom_range(0, 1) == 0) begin
                udir = 1'b0;
            end
            step(udir, udata, (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
